// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared types and chain-geometry helpers for the gate1 IJTAG TDR.
// FIREBIRD7_IN_GATE1_TDR_PARITY_EN adds a parity bit at the top of the chain.
package firebird7_in_gate1_tdr_pkg;

    typedef enum logic [1:0] {
        TDR_IDLE,
        TDR_CAPTURE,
        TDR_SHIFT,
        TDR_UPDATE
    } tdr_op_e;

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic int sel_idx(input int width);
        return width;
    endfunction

    function automatic int par_idx(input int width);
        return width + 1;
    endfunction

    function automatic int chain_len(input int width);
        return PARITY_EN ? par_idx(width) + 1 : sel_idx(width) + 1;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tdr_sr.sv
// Capture/shift chain of the gate1 TDR, including the capture-side parity generator
// used when FIREBIRD7_IN_GATE1_TDR_PARITY_EN is defined.
module firebird7_in_gate1_tdr_sr
    import firebird7_in_gate1_tdr_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        capture,
    input  logic                        shift,
    input  logic                        si,
    input  logic                        sel_bit,
    input  logic [WIDTH-1:0]            data_obs,
    output logic [chain_len(WIDTH)-1:0] sr
);

    localparam int L = chain_len(WIDTH);

    logic [WIDTH:0] payload;
    logic [L-1:0]   cap_val;

    assign payload = {sel_bit, data_obs};

    // Even parity over the payload so a captured word reloads without tripping the check.
    generate
        if (PARITY_EN) begin : g_par
            assign cap_val = {^payload, payload};
        end else begin : g_nopar
            assign cap_val = payload;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (capture) begin
            sr <= cap_val;
        end else if (shift) begin
            sr <= {si, sr[L-1:1]};
        end
    end

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w3.sv
// IJTAG TDR driving the select/override side of the firebird7 gate1 3-bit data mux.
// Optional update-parity checking is enabled by FIREBIRD7_IN_GATE1_TDR_PARITY_EN.
module firebird7_in_gate1_tessent_tdr_w3
    import firebird7_in_gate1_tdr_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_obs,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    ,
    output logic             parity_error
`endif
);

    localparam int L   = chain_len(WIDTH);
    localparam int SEL = sel_idx(WIDTH);

    tdr_op_e        op;
    logic [L-1:0]   sr;
    logic [WIDTH:0] ur;
    logic           commit_ok;

    // One operation per edge; lower-priority enables are dropped, not queued.
    always_comb begin
        op = TDR_IDLE;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                op = TDR_CAPTURE;
            end else if (ijtag_se) begin
                op = TDR_SHIFT;
            end else if (ijtag_ue) begin
                op = TDR_UPDATE;
            end
        end
    end

    firebird7_in_gate1_tdr_sr #(
        .WIDTH(WIDTH)
    ) u_sr (
        .clk      (ijtag_tck),
        .rst      (ijtag_reset),
        .capture  (op == TDR_CAPTURE),
        .shift    (op == TDR_SHIFT),
        .si       (ijtag_si),
        .sel_bit  (ur[SEL]),
        .data_obs (functional_data_obs),
        .sr       (sr)
    );

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    assign commit_ok = ~^sr;

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            parity_error <= 1'b0;
        end else if (op == TDR_UPDATE && !commit_ok) begin
            parity_error <= 1'b1;
        end
    end
`else
    assign commit_ok = 1'b1;
`endif

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            ur <= '0;
        end else if (op == TDR_UPDATE && commit_ok) begin
            ur <= sr[SEL:0];
        end
    end

    assign ijtag_so       = sr[0];
    assign ijtag_select   = ur[SEL];
    assign ijtag_data_out = ur[WIDTH-1:0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3.sv
// Directed table-driven bench for the gate1 TDR; parity rows are added when
// FIREBIRD7_IN_GATE1_TDR_PARITY_EN is defined.
module tb_firebird7_in_gate1_tessent_tdr_w3;

    logic       tck = 1'b0;
    logic       rst, sel, ce, se, ue, si;
    logic [2:0] fdo;
    logic       so, sel_out;
    logic [2:0] data_out;
    logic       perr;

    always #5 tck = ~tck;

    firebird7_in_gate1_tessent_tdr_w3 #(.WIDTH(3)) dut (
        .ijtag_tck           (tck),
        .ijtag_reset         (rst),
        .ijtag_sel           (sel),
        .ijtag_ce            (ce),
        .ijtag_se            (se),
        .ijtag_ue            (ue),
        .ijtag_si            (si),
        .ijtag_so            (so),
        .functional_data_obs (fdo),
        .ijtag_select        (sel_out),
        .ijtag_data_out      (data_out)
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        ,
        .parity_error        (perr)
`endif
    );

`ifndef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    assign perr = 1'b0;
`endif

    typedef struct {
        logic       rst, sel, ce, se, ue, si;
        logic [2:0] fdo;
        logic       exp_sel;
        logic [2:0] exp_data;
        logic       exp_so;
        logic       exp_perr;
    } vec_t;

    vec_t  vecs[$];
    string names[$];
    int    checks = 0;
    int    errors = 0;

    task automatic add(input string n, input logic r, input logic s, input logic c,
                       input logic sh, input logic u, input logic i, input logic [2:0] f,
                       input logic es, input logic [2:0] ed, input logic eso, input logic ep);
        vec_t v;
        v.rst = r; v.sel = s; v.ce = c; v.se = sh; v.ue = u; v.si = i; v.fdo = f;
        v.exp_sel = es; v.exp_data = ed; v.exp_so = eso; v.exp_perr = ep;
        vecs.push_back(v);
        names.push_back(n);
    endtask

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge tck);
        rst = v.rst; sel = v.sel; ce = v.ce; se = v.se; ue = v.ue; si = v.si; fdo = v.fdo;
        @(posedge tck);
        #1;
    endtask

    initial begin
        vec_t v;
        rst = 1'b0; sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0; fdo = 3'b000;

        //   name          rst sel ce se ue si fdo     sel data    so perr
        add("reset",        1, 1, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 0);
        add("load_sh1",     0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 0, 0);
        add("load_sh2",     0, 1, 0, 1, 0, 0, 3'b000, 0, 3'b000, 0, 0);
        add("load_sh3",     0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 0, 0);
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        add("load_sh4",     0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 0, 0);
        add("load_par",     0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 1, 0);
`else
        add("load_sh4",     0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 1, 0);
`endif
        add("update_101",   0, 1, 0, 0, 1, 0, 3'b000, 1, 3'b101, 1, 0);
        add("capture_110",  0, 1, 1, 0, 0, 0, 3'b110, 1, 3'b101, 0, 0);
        add("unload1",      0, 1, 0, 1, 0, 0, 3'b110, 1, 3'b101, 1, 0);
        add("unload2",      0, 1, 0, 1, 0, 0, 3'b110, 1, 3'b101, 1, 0);
        add("unload3",      0, 1, 0, 1, 0, 0, 3'b110, 1, 3'b101, 1, 0);
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        add("unload_par",   0, 1, 0, 1, 0, 0, 3'b110, 1, 3'b101, 1, 0);
`endif
        add("unload_end",   0, 1, 0, 1, 0, 0, 3'b110, 1, 3'b101, 0, 0);
        add("ce_se_cap",    0, 1, 1, 1, 0, 1, 3'b011, 1, 3'b101, 1, 0);
        add("desel_ce_ue",  0, 0, 1, 0, 1, 0, 3'b100, 1, 3'b101, 1, 0);
        add("desel_se",     0, 0, 0, 1, 0, 0, 3'b100, 1, 3'b101, 1, 0);
        add("update_011",   0, 1, 0, 0, 1, 0, 3'b100, 1, 3'b011, 1, 0);
        add("ce_ue_cap",    0, 1, 1, 0, 1, 0, 3'b000, 1, 3'b011, 0, 0);
        add("se_ue_shift",  0, 1, 0, 1, 1, 0, 3'b000, 1, 3'b011, 0, 0);
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        add("update_100",   0, 1, 0, 0, 1, 0, 3'b000, 1, 3'b100, 0, 0);
        add("mid_sh1",      0, 1, 0, 1, 0, 1, 3'b000, 1, 3'b100, 0, 0);
        add("mid_sh2",      0, 1, 0, 1, 0, 1, 3'b000, 1, 3'b100, 1, 0);
`else
        add("update_100",   0, 1, 0, 0, 1, 0, 3'b000, 0, 3'b100, 0, 0);
        add("mid_sh1",      0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b100, 0, 0);
        add("mid_sh2",      0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b100, 1, 0);
`endif
        add("mid_reset",    1, 1, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 0);
        add("post_rst_ue",  0, 1, 0, 0, 1, 0, 3'b000, 0, 3'b000, 0, 0);
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        add("bad_sh1",      0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 0, 0);
        add("bad_sh2",      0, 1, 0, 1, 0, 0, 3'b000, 0, 3'b000, 0, 0);
        add("bad_sh3",      0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 0, 0);
        add("bad_sh4",      0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 0, 0);
        add("bad_par",      0, 1, 0, 1, 0, 0, 3'b000, 0, 3'b000, 1, 0);
        add("bad_update",   0, 1, 0, 0, 1, 0, 3'b000, 0, 3'b000, 1, 1);
        add("good_sh1",     0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 0, 1);
        add("good_sh2",     0, 1, 0, 1, 0, 0, 3'b000, 0, 3'b000, 1, 1);
        add("good_sh3",     0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 1, 1);
        add("good_sh4",     0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 0, 1);
        add("good_par",     0, 1, 0, 1, 0, 1, 3'b000, 0, 3'b000, 1, 1);
        add("good_update",  0, 1, 0, 0, 1, 0, 3'b000, 1, 3'b101, 1, 1);
        add("perr_reset",   1, 1, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 0);
`endif

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            drive(v);
            chk({names[k], ".select"}, {7'd0, sel_out}, {7'd0, v.exp_sel});
            chk({names[k], ".data"}, {5'd0, data_out}, {5'd0, v.exp_data});
            chk({names[k], ".so"}, {7'd0, so}, {7'd0, v.exp_so});
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
            chk({names[k], ".perr"}, {7'd0, perr}, {7'd0, v.exp_perr});
`endif
        end

        // Deselected TDR must ignore every enable combination and hold all state.
        for (int k = 0; k < 8; k++) begin
            v.rst = 1'b0; v.sel = 1'b0;
            v.ce = k[0]; v.se = k[1]; v.ue = k[2]; v.si = 1'b1; v.fdo = 3'b111;
            drive(v);
            chk("desel_hold.select", {7'd0, sel_out}, 8'd0);
            chk("desel_hold.data", {5'd0, data_out}, 8'd0);
            chk("desel_hold.so", {7'd0, so}, 8'd0);
        end

        // Outputs must stay put through a full load and only move on the update edge.
        v.rst = 1'b0; v.sel = 1'b1; v.ce = 1'b0; v.se = 1'b1; v.ue = 1'b0; v.fdo = 3'b000;
        for (int k = 0; k < (dut.L); k++) begin
            v.si = (k == 1) ? 1'b0 : 1'b1;
            drive(v);
            chk("load_hold.select", {7'd0, sel_out}, 8'd0);
            chk("load_hold.data", {5'd0, data_out}, 8'd0);
        end
        v.se = 1'b0; v.ue = 1'b1; v.si = 1'b0;
        drive(v);
        chk("load_commit.select", {7'd0, sel_out}, 8'd1);
        chk("load_commit.data", {5'd0, data_out}, 8'h05);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
